// File: rtl/tube_pkg.sv
// Shared definitions for the tube register-channel schedulers:
// FSM state encoding, channel indices, default timeout and a one-hot helper.
package tube_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] CH_R1 = 2'd0;
  localparam logic [1:0] CH_R2 = 2'd1;
  localparam logic [1:0] CH_R3 = 2'd2;
  localparam logic [1:0] CH_R4 = 2'd3;

  localparam int NUM_CH_DEF      = 4;
  localparam int CLR_TIMEOUT_DEF = 7;

  // One-hot decode of a channel index into a select vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping modulo 4. Shared by the tube register-channel schedulers.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  // Scan offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        idx   = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hp_chan_arbiter.sv
// Parasite-side scheduler for the four host-to-parasite register channels.
// Grants one pending channel, strobes it once, waits for its flag to drop,
// then hands the captured byte to a single valid/ready consumer.
// Optional build macro TUBE_HP_ARB_R4_PRIO_EN: channel 3 (R4) wins whenever
// pending, and serving it leaves the round-robin pointer untouched.
module hp_chan_arbiter
  import tube_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CLR_TIMEOUT = CLR_TIMEOUT_DEF
) (
  input  logic                  p_phi2,
  input  logic                  p_rst_b,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [NUM_CH-1:0]     p_data_available,
  input  logic [8*NUM_CH-1:0]   p_data,
  output logic [NUM_CH-1:0]     p_select,
  output logic                  p_rdnw,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [1:0]            out_chan,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  clr_err,
  input  logic                  clr_err_ack
);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [1:0]  out_chan_q, out_chan_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        clr_err_q, clr_err_d;

  logic [NUM_CH-1:0] pending;
  logic [1:0]        pick_idx;
  logic              pick_found;
  logic              flag_high;
  logic              timeout_hit;

  assign pending     = p_data_available & ch_enable;
  assign flag_high   = p_data_available[grant_q];
  assign timeout_hit = (cnt_q == 8'(CLR_TIMEOUT - 1));

  rr_pick4 u_pick (
    .req   (pending),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge p_phi2) begin
    // NOTE: reset is sampled on the clock edge only; p_rst_b is not in the sensitivity list.
    if (!p_rst_b) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
      out_chan_q <= '0;
      cnt_q      <= '0;
      clr_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      cnt_q      <= cnt_d;
      clr_err_q  <= clr_err_d;
    end
  end

  // Next-state logic: IDLE -> READ -> CLEAR -> HOLD -> IDLE.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_READ;
      ST_READ:  state_d = ST_CLEAR;
      ST_CLEAR: if (!flag_high || timeout_hit) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: grant, byte capture, clear timeout, pointer, error flag.
  always_comb begin
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    cnt_d      = cnt_q;
    clr_err_d  = clr_err_ack ? 1'b0 : clr_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
`ifdef TUBE_HP_ARB_R4_PRIO_EN
          grant_d = pending[CH_R4] ? CH_R4 : pick_idx;
`else
          grant_d = pick_idx;
`endif
        end
      end
      ST_READ: begin
        out_data_d = p_data[{grant_q, 3'b000} +: 8];
        out_chan_d = grant_q;
        cnt_d      = '0;
      end
      ST_CLEAR: begin
        if (flag_high) begin
          if (timeout_hit) clr_err_d = 1'b1;  // set beats a same-cycle ack
          else             cnt_d     = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
`ifdef TUBE_HP_ARB_R4_PRIO_EN
          if (grant_q != CH_R4) rr_ptr_d = grant_q + 2'd1;
`else
          rr_ptr_d = grant_q + 2'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state only; data/channel/error come straight from flops.
  always_comb begin
    p_select  = '0;
    p_rdnw    = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_READ: begin
        p_select = onehot4(grant_q);
        p_rdnw   = 1'b1;
      end
      ST_HOLD: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign clr_err  = clr_err_q;

endmodule
